// File: rtl/pipe_pkg.sv
// Shared pipeline types and stage payload widths.
// Imported by every pipeline stage and perf-counter block.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_st_e;

  localparam int WB_W  = 2;
  localparam int M_W   = 3;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  // WB + M + alu addr + store data + rd
  localparam int EXMEM_W = WB_W + M_W + XLEN + XLEN + REG_W;

endpackage

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating event counter with synchronous clear.
// Shared by the stage stall counter and other perf counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Inter-stage register with valid/ready handshake,
// flush, optional skid entry and stall counter.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              stat_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam bit SKID_EN = (SKID != 0);

  stage_st_e   state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic        in_fire;
  logic        out_fire;

  assign valid_o  = (state_q != EMPTY);
  assign ready_o  = SKID_EN ? (state_q != TWO)
                            : (!valid_o | ready_i);
  assign data_o   = main_q;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = data_i;
        end
      end
      ONE: begin
        if (in_fire && (out_fire || !SKID_EN)) begin
          main_d = data_i;
        end else if (in_fire) begin
          state_d = TWO;
          skid_d  = data_i;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // squash clears valids only; payload flops keep their contents
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .inc_i  (valid_o & ~ready_i),
    .clr_i  (stat_clr_i),
    .cnt_o  (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: default, 4-bit
// counter and no-skid instances share one stimulus.
module tb_pipe_stage_hs;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic vin = 1'b0;
  logic rin = 1'b0;
  logic clr = 1'b0;
  logic [EXMEM_W-1:0] din = '0;

  logic               d_rdy, d_vld;
  logic [EXMEM_W-1:0] d_dat;
  logic [15:0]        d_cnt;
  logic               s_rdy, s_vld;
  logic [7:0]         s_dat;
  logic [3:0]         s_cnt;
  logic               n_rdy, n_vld;
  logic [7:0]         n_dat;
  logic [15:0]        n_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_hs u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .valid_i(vin), .ready_o(d_rdy), .data_i(din),
    .valid_o(d_vld), .ready_i(rin), .data_o(d_dat),
    .stat_clr_i(clr), .stall_cnt_o(d_cnt)
  );

  pipe_stage_hs #(.DATA_W(8), .SKID(1), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .valid_i(vin), .ready_o(s_rdy), .data_i(din[7:0]),
    .valid_o(s_vld), .ready_i(rin), .data_o(s_dat),
    .stat_clr_i(clr), .stall_cnt_o(s_cnt)
  );

  pipe_stage_hs #(.DATA_W(8), .SKID(0), .CNT_W(16)) u_ns (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .valid_i(vin), .ready_o(n_rdy), .data_i(din[7:0]),
    .valid_o(n_vld), .ready_i(rin), .data_o(n_dat),
    .stat_clr_i(clr), .stall_cnt_o(n_cnt)
  );

  task automatic chk(input string tag,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // back-pressure vectors: inputs, then state after the edge
  int bp_v[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
  int bp_d[8] = '{1, 2, 3, 3, 3, 3, 4, 0};
  int bp_r[8] = '{1, 0, 0, 0, 1, 1, 1, 1};
  int bp_ov[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
  int bp_od[8] = '{1, 1, 1, 1, 2, 3, 4, 4};
  int bp_or[8] = '{1, 0, 0, 0, 1, 1, 1, 1};
  int bp_oc[8] = '{0, 1, 2, 3, 3, 3, 3, 3};

  initial begin
    bit m_vld;
    int m_dat, nxt, exp_out, r, m_rdy;

    // reset and streaming
    rst_n = 1'b0;
    step();
    step();
    chk("rst_valid", d_vld, 0);
    chk("rst_data", d_dat, 0);
    chk("rst_ready", d_rdy, 1);
    chk("rst_cnt", d_cnt, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      vin = 1'b1;
      din = EXMEM_W'(i);
      rin = 1'b1;
      step();
      chk($sformatf("strm_v%0d", i), d_vld, 1);
      chk($sformatf("strm_d%0d", i), d_dat, 80'(i));
    end
    vin = 1'b0;
    step();
    chk("strm_idle", d_vld, 0);
    chk("strm_cnt", d_cnt, 0);

    // back-pressure into the skid entry
    for (int i = 0; i < 8; i++) begin
      vin = bp_v[i][0];
      din = EXMEM_W'(bp_d[i]);
      rin = bp_r[i][0];
      step();
      chk($sformatf("bp_v%0d", i), d_vld, 80'(bp_ov[i]));
      chk($sformatf("bp_d%0d", i), d_dat, 80'(bp_od[i]));
      chk($sformatf("bp_r%0d", i), d_rdy, 80'(bp_or[i]));
      chk($sformatf("bp_c%0d", i), d_cnt, 80'(bp_oc[i]));
    end

    // flush from TWO with a concurrent input
    vin = 1'b1; din = 'h11; rin = 1'b0;
    step();
    din = 'h22;
    step();
    chk("fl_two_rdy", d_rdy, 0);
    chk("fl_two_cnt", d_cnt, 4);
    flush = 1'b1; din = 'hAA;
    step();
    flush = 1'b0; vin = 1'b0; rin = 1'b1;
    chk("fl_valid", d_vld, 0);
    chk("fl_ready", d_rdy, 1);
    chk("fl_data_kept", d_dat, 'h11);
    chk("fl_cnt", d_cnt, 5);
    step();
    chk("fl_still_empty", d_vld, 0);
    vin = 1'b1; din = 'h33;
    step();
    chk("fl_new_v", d_vld, 1);
    chk("fl_new_d", d_dat, 'h33);
    vin = 1'b0;
    step();
    chk("fl_no_aa", d_vld, 0);

    // saturation
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vin = 1'b1; din = 'h05; rin = 1'b0;
    step();
    vin = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt4", s_cnt, 15);
    chk("sat_cnt16", d_cnt, 20);
    chk("sat_hold", s_dat, 'h05);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnt4", s_cnt, 0);
    chk("clr_cnt16", d_cnt, 0);
    step();
    chk("clr_resume", s_cnt, 1);

    // reset while in TWO
    vin = 1'b1; din = 'h06;
    step();
    chk("rm_two_rdy", d_rdy, 0);
    rst_n = 1'b0; flush = 1'b1;
    step();
    rst_n = 1'b1; flush = 1'b0;
    chk("rm_valid", d_vld, 0);
    chk("rm_data", d_dat, 0);
    chk("rm_ready", d_rdy, 1);
    chk("rm_cnt", d_cnt, 0);
    din = 'h07; rin = 1'b1;
    step();
    chk("rm_accept_v", d_vld, 1);
    chk("rm_accept_d", d_dat, 'h07);

    // no-skid mode, ready_i toggling
    rst_n = 1'b0; vin = 1'b0;
    step();
    rst_n = 1'b1;
    m_vld = 1'b0; m_dat = 0; nxt = 1; exp_out = 1;
    for (int i = 0; i < 12; i++) begin
      r = i % 2;
      vin = 1'b1;
      din = EXMEM_W'(nxt);
      rin = r[0];
      #1;
      m_rdy = (!m_vld || r == 1) ? 1 : 0;
      chk($sformatf("ns_rdy%0d", i), n_rdy, 80'(m_rdy));
      if (m_vld && r == 1) begin
        chk($sformatf("ns_ord%0d", i), n_dat,
            80'(exp_out));
        exp_out++;
      end
      if (m_rdy == 1) begin
        m_vld = 1'b1;
        m_dat = nxt;
        nxt++;
      end else if (m_vld && r == 1) begin
        m_vld = 1'b0;
      end
      step();
      chk($sformatf("ns_v%0d", i), n_vld, 80'(m_vld));
      chk($sformatf("ns_d%0d", i), n_dat, 80'(m_dat));
    end
    vin = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
